// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: read-owner tag and byte-enable constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } mem_owner_e;

  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/mem_grant_logic.sv
// Single-command-per-cycle grant between fetch (I) and load/store (D), with an I starvation
// counter that forces I to win after MAX_IWAIT consecutive denials.
module mem_grant_logic #(
  parameter int unsigned MAX_IWAIT = 4,
  localparam int unsigned IWW = $clog2(MAX_IWAIT + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           i_valid_i,
  input  logic           d_valid_i,
  output logic           grant_i_o,
  output logic           grant_d_o,
  output logic [IWW-1:0] i_wait_o
);

  localparam logic [IWW-1:0] WaitMax = IWW'(MAX_IWAIT);

  logic [IWW-1:0] i_wait_d, i_wait_q;
  logic           i_starved;

  always_comb begin
    i_starved = (i_wait_q >= WaitMax);
    // D has priority unless I has waited long enough.
    grant_i_o = i_valid_i & (~d_valid_i | i_starved);
    grant_d_o = d_valid_i & ~grant_i_o;
  end

  always_comb begin
    i_wait_d = '0;
    if (i_valid_i && !grant_i_o) begin
      i_wait_d = (i_wait_q == WaitMax) ? i_wait_q : i_wait_q + IWW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_wait_q <= '0;
    end else begin
      i_wait_q <= i_wait_d;
    end
  end

  assign i_wait_o = i_wait_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port byte-lane memory between fetch (I) and load/store (D) and steers
// each 1-cycle-latency read response back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = 8192,
  parameter int unsigned MAX_IWAIT = 4,
  localparam int unsigned AW = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          reset_n,

  input  logic          i_req_valid,
  output logic          i_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_rsp_valid,
  output logic [31:0]   i_rsp_data,

  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_req_we,
  input  logic [3:0]    d_req_be,
  input  logic [AW-1:0] d_req_addr,
  input  logic [31:0]   d_req_wdata,
  output logic          d_rsp_valid,
  output logic [31:0]   d_rsp_data,

  output logic          mem_read_cmd_valid,
  output logic          mem_write_cmd_valid,
  output logic          mem_write_data_valid,
  output logic [3:0]    mem_write_data_size,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data,
  input  logic          mem_read_data_valid,

  output logic          proto_err
);

  localparam int unsigned IWW = $clog2(MAX_IWAIT + 1);

  logic           grant_i, grant_d;
  logic [IWW-1:0] i_wait;
  logic           d_write;

  mem_owner_e rd_tag_d, rd_tag_q;
  logic       i_rsp_valid_d, i_rsp_valid_q;
  logic       d_rsp_valid_d, d_rsp_valid_q;
  logic [31:0] i_rsp_data_d, i_rsp_data_q;
  logic [31:0] d_rsp_data_d, d_rsp_data_q;
  logic       proto_err_d, proto_err_q;

  mem_grant_logic #(
    .MAX_IWAIT (MAX_IWAIT)
  ) u_grant (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .i_valid_i (i_req_valid),
    .d_valid_i (d_req_valid),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d),
    .i_wait_o  (i_wait)
  );

  always_comb begin
    d_write              = grant_d & d_req_we;
    i_req_ready          = grant_i;
    d_req_ready          = grant_d;
    mem_addr             = grant_d ? d_req_addr : i_req_addr;
    mem_read_cmd_valid   = grant_i | (grant_d & ~d_req_we);
    mem_write_cmd_valid  = d_write;
    mem_write_data_valid = d_write;
    mem_write_data_size  = d_write ? d_req_be : BE_NONE;
    mem_write_data       = d_req_wdata;
  end

  // Tag the read issued this cycle so its data can be steered when it returns.
  always_comb begin
    rd_tag_d = OWN_NONE;
    if (grant_i) begin
      rd_tag_d = OWN_I;
    end else if (grant_d && !d_req_we) begin
      rd_tag_d = OWN_D;
    end
  end

  always_comb begin
    i_rsp_valid_d = mem_read_data_valid & (rd_tag_q == OWN_I);
    d_rsp_valid_d = mem_read_data_valid & (rd_tag_q == OWN_D);
    i_rsp_data_d  = i_rsp_valid_d ? mem_read_data : i_rsp_data_q;
    d_rsp_data_d  = d_rsp_valid_d ? mem_read_data : d_rsp_data_q;
    // Data strobe must appear exactly when a read is outstanding.
    proto_err_d   = proto_err_q | (mem_read_data_valid != (rd_tag_q != OWN_NONE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_tag_q      <= OWN_NONE;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_data_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      rd_tag_q      <= rd_tag_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_data_q  <= d_rsp_data_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign proto_err   = proto_err_q;

  logic unused_wait;
  assign unused_wait = ^i_wait;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned DEPTH     = 8192;
  localparam int unsigned MAX_IWAIT = 4;
  localparam int unsigned AW        = $clog2(DEPTH) + 2;
  localparam int unsigned NWORDS    = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req_valid, i_req_ready, i_rsp_valid;
  logic [AW-1:0] i_req_addr;
  logic [31:0]   i_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [3:0]    d_req_be;
  logic [AW-1:0] d_req_addr;
  logic [31:0]   d_req_wdata, d_rsp_data;
  logic          mem_read_cmd_valid, mem_write_cmd_valid, mem_write_data_valid;
  logic [3:0]    mem_write_data_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data, mem_read_data;
  logic          mem_read_data_valid;
  logic          proto_err;

  logic          mem_clear;
  logic          inject;
  logic          mem_rvalid_q;
  logic [31:0]   mem_arr [0:NWORDS-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] ref_mem [0:NWORDS-1];
  int          iw;
  logic        due_i_v, nxt_i_v, due_d_v, nxt_d_v;
  logic [31:0] due_i_d, nxt_i_d, due_d_d, nxt_d_d;
  logic [31:0] exp_i_data, exp_d_data;
  logic        exp_proto;
  int          deny_run, max_deny;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DEPTH     (DEPTH),
    .MAX_IWAIT (MAX_IWAIT)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .i_req_valid          (i_req_valid),
    .i_req_ready          (i_req_ready),
    .i_req_addr           (i_req_addr),
    .i_rsp_valid          (i_rsp_valid),
    .i_rsp_data           (i_rsp_data),
    .d_req_valid          (d_req_valid),
    .d_req_ready          (d_req_ready),
    .d_req_we             (d_req_we),
    .d_req_be             (d_req_be),
    .d_req_addr           (d_req_addr),
    .d_req_wdata          (d_req_wdata),
    .d_rsp_valid          (d_rsp_valid),
    .d_rsp_data           (d_rsp_data),
    .mem_read_cmd_valid   (mem_read_cmd_valid),
    .mem_write_cmd_valid  (mem_write_cmd_valid),
    .mem_write_data_valid (mem_write_data_valid),
    .mem_write_data_size  (mem_write_data_size),
    .mem_addr             (mem_addr),
    .mem_write_data       (mem_write_data),
    .mem_read_data        (mem_read_data),
    .mem_read_data_valid  (mem_read_data_valid),
    .proto_err            (proto_err)
  );

  // Memory macro: byte-lane write, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int w = 0; w < NWORDS; w++) mem_arr[w] <= '0;
    end else if (mem_write_cmd_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_write_data_size[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
    end
    mem_read_data <= mem_arr[mem_addr[7:2]];
    mem_rvalid_q  <= mem_read_cmd_valid;
  end

  assign mem_read_data_valid = mem_rvalid_q | inject;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    iw = 0;
    due_i_v = 1'b0; nxt_i_v = 1'b0; due_d_v = 1'b0; nxt_d_v = 1'b0;
    due_i_d = '0; nxt_i_d = '0; due_d_d = '0; nxt_d_d = '0;
    exp_i_data = '0; exp_d_data = '0;
    exp_proto = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, advance the model. Entered 1 ns after posedge.
  task automatic step(input logic iv, input logic [AW-1:0] ia, input logic dv, input logic dwe,
                      input logic [3:0] dbe, input logic [AW-1:0] da, input logic [31:0] dwd,
                      input logic inj);
    logic gi, gd;
    int   wi;
    i_req_valid = iv; i_req_addr = ia;
    d_req_valid = dv; d_req_we = dwe; d_req_be = dbe; d_req_addr = da; d_req_wdata = dwd;
    inject = inj;
    #2;
    gi = iv && (!dv || iw >= MAX_IWAIT);
    gd = dv && !gi;
    check_eq("i_req_ready", 32'(i_req_ready), 32'(gi));
    check_eq("d_req_ready", 32'(d_req_ready), 32'(gd));
    check_eq("mem_rd_cmd", 32'(mem_read_cmd_valid), 32'(gi || (gd && !dwe)));
    check_eq("mem_wr_cmd", 32'(mem_write_cmd_valid), 32'(gd && dwe));
    check_eq("mem_wr_dvalid", 32'(mem_write_data_valid), 32'(gd && dwe));
    check_eq("mem_wr_size", 32'(mem_write_data_size), (gd && dwe) ? 32'(dbe) : 32'd0);
    check_eq("mem_addr", 32'(mem_addr), gd ? 32'(da) : 32'(ia));
    if (gd && dwe) check_eq("mem_wdata", mem_write_data, dwd);
    if (due_i_v) exp_i_data = due_i_d;
    if (due_d_v) exp_d_data = due_d_d;
    check_eq("i_rsp_valid", 32'(i_rsp_valid), 32'(due_i_v));
    check_eq("i_rsp_data", i_rsp_data, exp_i_data);
    check_eq("d_rsp_valid", 32'(d_rsp_valid), 32'(due_d_v));
    check_eq("d_rsp_data", d_rsp_data, exp_d_data);
    check_eq("proto_err", 32'(proto_err), 32'(exp_proto));
    if (iv && !i_req_ready) deny_run++; else deny_run = 0;
    if (deny_run > max_deny) max_deny = deny_run;
    // Advance model
    iw = (iv && !gi) ? ((iw < MAX_IWAIT) ? iw + 1 : iw) : 0;
    due_i_v = nxt_i_v; due_i_d = nxt_i_d;
    due_d_v = nxt_d_v; due_d_d = nxt_d_d;
    nxt_i_v = gi; nxt_d_v = gd && !dwe;
    if (gi) nxt_i_d = ref_mem[ia[7:2]];
    if (gd) begin
      wi = int'(da[7:2]);
      if (dwe) begin
        for (int b = 0; b < 4; b++) if (dbe[b]) ref_mem[wi][8*b +: 8] = dwd[8*b +: 8];
      end else begin
        nxt_d_d = ref_mem[wi];
      end
    end
    if (inj) exp_proto = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_i_rsp_valid"}, 32'(i_rsp_valid), 32'd0);
    check_eq({tag, "_d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
    check_eq({tag, "_i_rsp_data"}, i_rsp_data, 32'd0);
    check_eq({tag, "_d_rsp_data"}, d_rsp_data, 32'd0);
    check_eq({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    check_eq({tag, "_strobes"}, 32'({i_req_ready, d_req_ready, mem_read_cmd_valid,
                                      mem_write_cmd_valid, mem_write_data_valid}), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a_i, a_d;
    reset_n = 1'b0; mem_clear = 1'b1; inject = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_be = '0; d_req_addr = '0; d_req_wdata = '0;
    for (int w = 0; w < NWORDS; w++) ref_mem[w] = '0;
    model_reset();
    deny_run = 0; max_deny = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mem_clear = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // I-only read of a word written beforehand
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, AW'(32'h10), 32'hDEADBEEF, 1'b0);
    step(1'b1, AW'(32'h10), 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    idle(2);
    check_eq("i_only_data", i_rsp_data, 32'hDEADBEEF);

    // Partial write then immediate read of the same word
    step(1'b0, '0, 1'b1, 1'b1, 4'b0011, AW'(32'h20), 32'hAABBCCDD, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 4'h0, AW'(32'h20), 32'h0, 1'b0);
    idle(2);
    check_eq("wr_then_rd", d_rsp_data, 32'h0000CCDD);

    // Both requesters continuously valid
    deny_run = 0; max_deny = 0;
    for (int k = 0; k < 15; k++)
      step(1'b1, AW'(k * 4), 1'b1, 1'b0, 4'h0, AW'(32'h4), 32'h0, 1'b0);
    idle(2);
    check_eq("max_i_deny", 32'(max_deny), 32'(MAX_IWAIT));

    // Alternating I and D reads
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) step(1'b1, AW'(32'h0), 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
      else            step(1'b0, '0, 1'b1, 1'b0, 4'h0, AW'(32'h4), 32'h0, 1'b0);
    end
    idle(2);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      a_i = AW'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(0, 3));
      a_d = AW'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, a_i, $urandom_range(0, 2) != 0, 1'($urandom),
           4'($urandom), a_d, $urandom, 1'b0);
    end
    idle(3);

    // Spurious read-data strobe makes proto_err sticky
    step(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1);
    idle(3);
    check_eq("proto_sticky", 32'(proto_err), 32'd1);

    // Reset the cycle after a D read is accepted
    step(1'b0, '0, 1'b1, 1'b0, 4'h0, AW'(32'h8), 32'h0, 1'b0);
    i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0; inject = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("in_rst");
    end
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    idle(3);
    for (int k = 0; k < 40; k++) begin
      a_i = AW'($urandom_range(0, NWORDS - 1) * 4);
      a_d = AW'($urandom_range(0, NWORDS - 1) * 4);
      step(1'($urandom), a_i, 1'($urandom), 1'($urandom), 4'($urandom), a_d, $urandom, 1'b0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
